// File: rtl/lamp_sequence_checker_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : lamp_sequence_checker_if                               |
// | Brief   : lamp bus plus checker status; master drives the lamps  |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface lamp_sequence_checker_if #(
  parameter int CNT_W = 8
);
  logic [0:2]       light;
  logic             clr;
  logic             locked;
  logic [1:0]       phase;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output light, clr,
    input  locked, phase, err, err_code, cycle_cnt
  );

  modport slave (
    input  light, clr,
    output locked, phase, err, err_code, cycle_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lamp_sequence_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : lamp_sequence_checker                                  |
// | Brief   : monitors the R->G->Y lamp bus for dwell/sequence errors |
// |           LAMP_CHK_STICKY_EN: err/err_code hold until clr        |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module lamp_sequence_checker #(
  parameter int DWELL_MIN = 1,
  parameter int DWELL_MAX = 1,
  parameter int CNT_W     = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  lamp_sequence_checker_if.slave bus
);

  localparam logic [1:0] c_sync   = 2'd0;
  localparam logic [1:0] c_red    = 2'd1;
  localparam logic [1:0] c_green  = 2'd2;
  localparam logic [1:0] c_yellow = 2'd3;

  localparam logic [1:0] c_illegal   = 2'd0;
  localparam logic [1:0] c_sequence  = 2'd1;
  localparam logic [1:0] c_understay = 2'd2;
  localparam logic [1:0] c_overstay  = 2'd3;

  localparam int              c_dw_w = $clog2(DWELL_MAX + 2);
  localparam logic [c_dw_w-1:0] c_dmin = c_dw_w'(DWELL_MIN);
  localparam logic [c_dw_w-1:0] c_dmax = c_dw_w'(DWELL_MAX);
  localparam logic [c_dw_w-1:0] c_one  = c_dw_w'(1);

`ifdef LAMP_CHK_STICKY_EN
  localparam logic c_sticky = 1'b1;
`else
  localparam logic c_sticky = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [c_dw_w-1:0] r_dwell;
  logic              r_locked;
  logic              r_err;
  logic [1:0]        r_code;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_lamp;
  logic [1:0]        w_succ;
  logic [1:0]        w_state_nx;
  logic [c_dw_w-1:0] w_dwell_nx;
  logic              w_err_hit;
  logic [1:0]        w_err_code;
  logic              w_cyc_inc;

  // Phase encoding doubles as the lamp decode; c_sync marks an illegal code.
  always_comb begin
    w_lamp = c_sync;
    case (bus.light)
      3'b100:  w_lamp = c_red;
      3'b010:  w_lamp = c_green;
      3'b001:  w_lamp = c_yellow;
      default: w_lamp = c_sync;
    endcase
  end

  always_comb begin
    w_succ = c_sync;
    case (r_state)
      c_red:    w_succ = c_green;
      c_green:  w_succ = c_yellow;
      c_yellow: w_succ = c_red;
      default:  w_succ = c_sync;
    endcase
  end

  // Every error relocks onto the offending lamp, or falls back to sync if illegal.
  always_comb begin
    w_state_nx = r_state;
    w_dwell_nx = r_dwell;
    w_err_hit  = 1'b0;
    w_err_code = c_illegal;
    w_cyc_inc  = 1'b0;
    if (r_state == c_sync) begin
      if (w_lamp != c_sync) begin
        w_state_nx = w_lamp;
        w_dwell_nx = c_one;
      end
    end else if (w_lamp == c_sync) begin
      w_err_hit  = 1'b1;
      w_err_code = c_illegal;
      w_state_nx = c_sync;
      w_dwell_nx = '0;
    end else if (w_lamp == r_state) begin
      if (r_dwell < c_dmax) begin
        w_dwell_nx = r_dwell + c_one;
      end else begin
        w_err_hit  = 1'b1;
        w_err_code = c_overstay;
        w_dwell_nx = c_one;
      end
    end else if (w_lamp == w_succ) begin
      w_state_nx = w_lamp;
      w_dwell_nx = c_one;
      if (r_dwell < c_dmin) begin
        w_err_hit  = 1'b1;
        w_err_code = c_understay;
      end else begin
        w_cyc_inc = (r_state == c_yellow);
      end
    end else begin
      w_err_hit  = 1'b1;
      w_err_code = c_sequence;
      w_state_nx = w_lamp;
      w_dwell_nx = c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_sync;
      r_dwell  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= c_illegal;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_dwell  <= w_dwell_nx;
      r_locked <= (w_state_nx != c_sync);
      // In sticky mode a fresh error on the clearing edge still wins.
      r_err    <= w_err_hit | (c_sticky & r_err & ~bus.clr);
      if (w_err_hit && (!c_sticky || !r_err || bus.clr)) begin
        r_code <= w_err_code;
      end
      if (w_cyc_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.locked    = r_locked;
  assign bus.phase     = r_state;
  assign bus.err       = r_err;
  assign bus.err_code  = r_code;
  assign bus.cycle_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lamp_sequence_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_lamp_sequence_checker                               |
// | Brief   : directed + random bench for two checker configurations |
// | Revision: 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_lamp_sequence_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lamp_sequence_checker_if #(.CNT_W(8)) ifa ();
  lamp_sequence_checker_if #(.CNT_W(2)) ifb ();

  lamp_sequence_checker #(.DWELL_MIN(1), .DWELL_MAX(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  lamp_sequence_checker #(.DWELL_MIN(2), .DWELL_MAX(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: lamp index 1..3 (0 = unlocked), samples held in current lamp.
  int dmin [2] = '{1, 2};
  int dmax [2] = '{1, 3};
  int cmod [2] = '{256, 4};
  int mp [2], mn [2], mcnt [2], merr [2], mcode [2];
  int gl [2], gleft [2];

`ifdef LAMP_CHK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mp[k] = 0; mn[k] = 0; mcnt[k] = 0; merr[k] = 0; mcode[k] = 0;
    end
  endtask

  function automatic int lamp_of(logic [2:0] s);
    if (s == 3'b100) return 1;
    if (s == 3'b010) return 2;
    if (s == 3'b001) return 3;
    return 0;
  endfunction

  task automatic model_step(int k, logic [2:0] s, logic c);
    int lamp = lamp_of(s);
    int e = -1;
    if (mp[k] == 0) begin
      if (lamp != 0) begin mp[k] = lamp; mn[k] = 1; end
    end else if (lamp == 0) begin
      e = 0; mp[k] = 0; mn[k] = 0;
    end else if (lamp == mp[k]) begin
      if (mn[k] + 1 > dmax[k]) begin e = 3; mn[k] = 1; end
      else mn[k] = mn[k] + 1;
    end else if (lamp == (mp[k] % 3) + 1) begin
      if (mn[k] < dmin[k]) e = 2;
      else if (mp[k] == 3) mcnt[k] = (mcnt[k] + 1) % cmod[k];
      mp[k] = lamp; mn[k] = 1;
    end else begin
      e = 1; mp[k] = lamp; mn[k] = 1;
    end
    if (STICKY) begin
      if (e >= 0 && (merr[k] == 0 || c)) mcode[k] = e;
      merr[k] = (e >= 0) ? 1 : ((merr[k] != 0 && !c) ? 1 : 0);
    end else begin
      merr[k] = (e >= 0) ? 1 : 0;
      if (e >= 0) mcode[k] = e;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, " a.locked"}, 32'(ifa.locked), 32'(mp[0] != 0));
    chk({tag, " a.phase"}, 32'(ifa.phase), 32'(mp[0]));
    chk({tag, " a.err"}, 32'(ifa.err), 32'(merr[0]));
    chk({tag, " a.err_code"}, 32'(ifa.err_code), 32'(mcode[0]));
    chk({tag, " a.cycle_cnt"}, 32'(ifa.cycle_cnt), 32'(mcnt[0]));
    chk({tag, " b.locked"}, 32'(ifb.locked), 32'(mp[1] != 0));
    chk({tag, " b.phase"}, 32'(ifb.phase), 32'(mp[1]));
    chk({tag, " b.err"}, 32'(ifb.err), 32'(merr[1]));
    chk({tag, " b.err_code"}, 32'(ifb.err_code), 32'(mcode[1]));
    chk({tag, " b.cycle_cnt"}, 32'(ifb.cycle_cnt), 32'(mcnt[1]));
  endtask

  task automatic step(string tag, logic [2:0] la, logic [2:0] lb, logic ca, logic cb);
    ifa.light = la; ifa.clr = ca;
    ifb.light = lb; ifb.clr = cb;
    @(posedge clk);
    #1;
    model_step(0, la, ca);
    model_step(1, lb, cb);
    check_all(tag);
  endtask

  function automatic logic [2:0] code_of(int lamp);
    return (lamp == 1) ? 3'b100 : (lamp == 2) ? 3'b010 : 3'b001;
  endfunction

  // Mostly well-formed cycles with occasional wrong lamps and illegal codes.
  function automatic logic [2:0] gen(int k);
    int r = $urandom_range(0, 99);
    if (r < 6) return 3'($urandom_range(0, 7));
    if (r < 12) return code_of($urandom_range(1, 3));
    if (gleft[k] == 0) begin
      gl[k] = (gl[k] % 3) + 1;
      gleft[k] = $urandom_range(dmin[k], dmax[k]);
    end
    gleft[k] = gleft[k] - 1;
    return code_of(gl[k]);
  endfunction

  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001, X = 3'b000;

  initial begin
    ifa.light = X; ifa.clr = 1'b0;
    ifb.light = X; ifb.clr = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step("seq_r", R, X, 1'b0, 1'b0);
      chk("seq locked after first edge", 32'(ifa.locked), 32'd1);
      step("seq_g", G, X, 1'b0, 1'b0);
      step("seq_y", Y, X, 1'b0, 1'b0);
    end
    chk("seq cycle_cnt", 32'(ifa.cycle_cnt), 32'd2);
    chk("seq final phase", 32'(ifa.phase), 32'd3);
    chk("seq no err", 32'(ifa.err), 32'd0);

    step("ill_r", R, X, 1'b0, 1'b0);
    step("ill_g", G, X, 1'b0, 1'b0);
    step("ill_110", 3'b110, X, 1'b0, 1'b0);
    chk("ill locked drop", 32'(ifa.locked), 32'd0);
    step("ill_relock", R, X, 1'b0, 1'b0);
    step("skip_y", Y, X, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) step("over_r", R, R, 1'b0, 1'b0);
    step("under_r", R, R, 1'b0, 1'b0);
    step("under_g", G, G, 1'b0, 1'b0);

    step("wrap", G, G, 1'b0, 1'b0);
    step("wrap", R, Y, 1'b0, 1'b0);
    step("wrap", G, Y, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step("wrap", Y, R, 1'b0, 1'b0);
      step("wrap", R, R, 1'b0, 1'b0);
      step("wrap", G, G, 1'b0, 1'b0);
      step("wrap", Y, G, 1'b0, 1'b0);
      step("wrap", R, Y, 1'b0, 1'b0);
      step("wrap", G, Y, 1'b0, 1'b0);
    end
    step("wrap_end", Y, R, 1'b0, 1'b0);

    // Asynchronous reset asserted well away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1 rst_n = 1'b1;

    for (int k = 0; k < 2; k++) begin gl[k] = 3; gleft[k] = 0; end
    for (int i = 0; i < 3000; i++) begin
      step("rand", gen(0), gen(1), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
